// File: rtl/writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | writeback_unit: shares the register-file write port between ALU and  |
// | load results; tracks pending loads per register for decode stalls.   |
// | Optional feature macro: WB_MISALIGN_TRAP_EN (misaligned-load trap).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module writeback_unit #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int REG_COUNT    = 32,
   parameter int LD_DEPTH     = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid_i,
   input  logic [ADDR_WIDTH-1:0] alu_rd_i,
   input  logic [DATA_WIDTH-1:0] alu_data_i,
   output logic                  alu_stall_o,
   input  logic                  ld_issue_valid_i,
   output logic                  ld_issue_ready_o,
   input  logic [ADDR_WIDTH-1:0] ld_rd_i,
   input  logic [2:0]            ld_funct3_i,
   input  logic [1:0]            ld_byte_off_i,
   input  logic                  mem_rsp_valid_i,
   output logic                  mem_rsp_ready_o,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
   output logic                  rf_we_o,
   output logic [ADDR_WIDTH-1:0] rf_wr_addr_o,
   output logic [DATA_WIDTH-1:0] rf_wr_data_o,
   output logic [REG_COUNT-1:0]  busy_o,
   output logic                  misalign_o
);

   localparam int c_ptr_w = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
   localparam int c_cnt_w = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int c_ent_w = ADDR_WIDTH + 5;
   localparam logic [c_ptr_w:0]   c_fifo_full  = (c_ptr_w + 1)'(LD_DEPTH);
   localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

   logic [c_ent_w-1:0]    fifo_q [LD_DEPTH];
   logic [c_ent_w-1:0]    fifo_d [LD_DEPTH];
   logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [c_ptr_w:0]      count_q, count_d;
   logic                  hold_valid_q, hold_valid_d;
   logic [ADDR_WIDTH-1:0] hold_rd_q, hold_rd_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic                  hold_mis_q, hold_mis_d;
   logic [c_cnt_w-1:0]    starve_cnt_q, starve_cnt_d;
   logic                  rf_we_q, rf_we_d;
   logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
   logic                  clr_valid_q, clr_valid_d;
   logic [ADDR_WIDTH-1:0] clr_rd_q, clr_rd_d;
   logic [REG_COUNT-1:0]  busy_q, busy_d;

   logic                  fifo_full, fifo_empty, issue_acc, rsp_acc;
   logic [ADDR_WIDTH-1:0] head_rd;
   logic [2:0]            head_f3;
   logic [1:0]            head_off;
   logic [7:0]            shift_b;
   logic [15:0]           shift_h;
   logic [DATA_WIDTH-1:0] fmt_data;
   logic                  fmt_mis;
   logic                  alu_want, hold_zero, hold_win, alu_win, hold_drain;
   logic [REG_COUNT-1:0]  set_mask, clr_mask;

   assign fifo_full        = (count_q == c_fifo_full);
   assign fifo_empty       = (count_q == '0);
   assign ld_issue_ready_o = !fifo_full && !(ld_rd_i != '0 && busy_q[ld_rd_i]);
   assign issue_acc        = ld_issue_valid_i && ld_issue_ready_o;
   assign mem_rsp_ready_o  = !fifo_empty && !hold_valid_q;
   assign rsp_acc          = mem_rsp_valid_i && mem_rsp_ready_o;
   assign {head_rd, head_f3, head_off} = fifo_q[rd_ptr_q];

   // Load formatting of the response against the tag at the FIFO head
   always_comb begin
      shift_b = 8'(mem_rsp_data_i >> {head_off, 3'b000});
      shift_h = 16'(mem_rsp_data_i >> {head_off[1], 4'b0000});
      case (head_f3)
         3'b000:  fmt_data = {{(DATA_WIDTH-8){shift_b[7]}}, shift_b};
         3'b100:  fmt_data = {{(DATA_WIDTH-8){1'b0}}, shift_b};
         3'b001:  fmt_data = {{(DATA_WIDTH-16){shift_h[15]}}, shift_h};
         3'b101:  fmt_data = {{(DATA_WIDTH-16){1'b0}}, shift_h};
         default: fmt_data = mem_rsp_data_i;
      endcase
`ifdef WB_MISALIGN_TRAP_EN
      fmt_mis = ((head_f3 == 3'b001 || head_f3 == 3'b101) && head_off[0]) ||
                (head_f3 == 3'b010 && head_off != 2'b00);
`else
      fmt_mis = 1'b0;
`endif
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (issue_acc) begin
         fifo_d[wr_ptr_q] = {ld_rd_i, ld_funct3_i, ld_byte_off_i};
         wr_ptr_d         = wr_ptr_q + c_ptr_w'(1);
      end
      if (rsp_acc) begin
         rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      end
      case ({issue_acc, rsp_acc})
         2'b10:   count_d = count_q + (c_ptr_w + 1)'(1);
         2'b01:   count_d = count_q - (c_ptr_w + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // A hold for r0 retires on its own without using the write port
   assign alu_want    = alu_valid_i && (alu_rd_i != '0);
   assign alu_stall_o = hold_valid_q && (starve_cnt_q == c_starve_max);
   assign hold_zero   = hold_valid_q && (hold_rd_q == '0);
   assign hold_win    = hold_valid_q && !hold_zero && (!alu_want || alu_stall_o);
   assign alu_win     = alu_want && !alu_stall_o && !hold_win;
   assign hold_drain  = hold_win || hold_zero;

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_rd_d    = hold_rd_q;
      hold_data_d  = hold_data_q;
      hold_mis_d   = hold_mis_q;
      starve_cnt_d = starve_cnt_q;
      if (rsp_acc) begin
         hold_valid_d = 1'b1;
         hold_rd_d    = head_rd;
         hold_data_d  = fmt_data;
         hold_mis_d   = fmt_mis;
      end else if (hold_drain) begin
         hold_valid_d = 1'b0;
      end
      if (!hold_valid_q || hold_drain) begin
         starve_cnt_d = '0;
      end else if (alu_win && starve_cnt_q != c_starve_max) begin
         starve_cnt_d = starve_cnt_q + c_cnt_w'(1);
      end
   end

   always_comb begin
      rf_we_d     = 1'b0;
      rf_addr_d   = rf_addr_q;
      rf_data_d   = rf_data_q;
      clr_valid_d = hold_win;
      clr_rd_d    = hold_rd_q;
      if (hold_win && !hold_mis_q) begin
         rf_we_d   = 1'b1;
         rf_addr_d = hold_rd_q;
         rf_data_d = hold_data_q;
      end else if (alu_win) begin
         rf_we_d   = 1'b1;
         rf_addr_d = alu_rd_i;
         rf_data_d = alu_data_i;
      end
   end

   // Busy bit clears in the cycle the register file captures the load
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_acc && ld_rd_i != '0) begin
         set_mask[ld_rd_i] = 1'b1;
      end
      if (clr_valid_q) begin
         clr_mask[clr_rd_q] = 1'b1;
      end
      busy_d = (busy_q & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LD_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         hold_valid_q <= 1'b0;
         hold_rd_q    <= '0;
         hold_data_q  <= '0;
         hold_mis_q   <= 1'b0;
         starve_cnt_q <= '0;
         rf_we_q      <= 1'b0;
         rf_addr_q    <= '0;
         rf_data_q    <= '0;
         clr_valid_q  <= 1'b0;
         clr_rd_q     <= '0;
         busy_q       <= '0;
      end else begin
         fifo_q       <= fifo_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         hold_valid_q <= hold_valid_d;
         hold_rd_q    <= hold_rd_d;
         hold_data_q  <= hold_data_d;
         hold_mis_q   <= hold_mis_d;
         starve_cnt_q <= starve_cnt_d;
         rf_we_q      <= rf_we_d;
         rf_addr_q    <= rf_addr_d;
         rf_data_q    <= rf_data_d;
         clr_valid_q  <= clr_valid_d;
         clr_rd_q     <= clr_rd_d;
         busy_q       <= busy_d;
      end
   end

   assign rf_we_o      = rf_we_q;
   assign rf_wr_addr_o = rf_addr_q;
   assign rf_wr_data_o = rf_data_q;
   assign busy_o       = busy_q;
`ifdef WB_MISALIGN_TRAP_EN
   assign misalign_o   = hold_win && hold_mis_q;
`else
   assign misalign_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_writeback_unit: scoreboard bench for writeback_unit.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_writeback_unit;
   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          alu_valid_i = 1'b0;
   logic [AW-1:0] alu_rd_i = '0;
   logic [DW-1:0] alu_data_i = '0;
   logic          alu_stall_o;
   logic          ld_issue_valid_i = 1'b0;
   logic          ld_issue_ready_o;
   logic [AW-1:0] ld_rd_i = '0;
   logic [2:0]    ld_funct3_i = '0;
   logic [1:0]    ld_byte_off_i = '0;
   logic          mem_rsp_valid_i = 1'b0;
   logic          mem_rsp_ready_o;
   logic [DW-1:0] mem_rsp_data_i = '0;
   logic          rf_we_o;
   logic [AW-1:0] rf_wr_addr_o;
   logic [DW-1:0] rf_wr_data_o;
   logic [31:0]   busy_o;
   logic          misalign_o;

   writeback_unit dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
      .alu_stall_o(alu_stall_o),
      .ld_issue_valid_i(ld_issue_valid_i), .ld_issue_ready_o(ld_issue_ready_o),
      .ld_rd_i(ld_rd_i), .ld_funct3_i(ld_funct3_i), .ld_byte_off_i(ld_byte_off_i),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
      .mem_rsp_data_i(mem_rsp_data_i),
      .rf_we_o(rf_we_o), .rf_wr_addr_o(rf_wr_addr_o), .rf_wr_data_o(rf_wr_data_o),
      .busy_o(busy_o), .misalign_o(misalign_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  errors = 0;
   int  checks = 0;

   // Every register-file write is popped against the scoreboard
   always @(negedge clk) begin
      if (rst_n && rf_we_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got r%0d=%h, none expected", rf_wr_addr_o, rf_wr_data_o);
         end else begin
            mon_e = exp_q.pop_front();
            if (rf_wr_addr_o !== mon_e.addr || rf_wr_data_o !== mon_e.data) begin
               errors++;
               $display("FAIL rf_write: got r%0d=%h, expected r%0d=%h",
                        rf_wr_addr_o, rf_wr_data_o, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [AW-1:0] rd, input logic [2:0] f3, input logic [1:0] off);
      ld_issue_valid_i = 1'b1;
      ld_rd_i          = rd;
      ld_funct3_i      = f3;
      ld_byte_off_i    = off;
      step();
      ld_issue_valid_i = 1'b0;
   endtask

   // Holds the response until accepted (bounded); optionally records the expected write
   task automatic respond(input logic [DW-1:0] word, input bit do_push,
                          input logic [AW-1:0] rd, input logic [DW-1:0] exp_data);
      int n = 0;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = word;
      if (do_push) push_exp(rd, exp_data);
      @(negedge clk);
      while (!mem_rsp_ready_o && n < 10) begin
         step();
         @(negedge clk);
         n++;
      end
      checks++;
      if (mem_rsp_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL rsp_accept_timeout: ready=%b, expected 1", mem_rsp_ready_o);
      end
      step();
      mem_rsp_valid_i = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d writes outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
      step();
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({rf_we_o, alu_stall_o, ld_issue_ready_o, mem_rsp_ready_o, misalign_o} !== 5'b00100) begin
         errors++;
         $display("FAIL reset_ctrl: got we/stall/iss_rdy/rsp_rdy/mis=%b, expected 00100",
                  {rf_we_o, alu_stall_o, ld_issue_ready_o, mem_rsp_ready_o, misalign_o});
      end
      checks++;
      if (busy_o !== 32'h0 || rf_wr_addr_o !== '0 || rf_wr_data_o !== '0) begin
         errors++;
         $display("FAIL reset_regs: busy=%h addr=%0d data=%h, expected all 0", busy_o, rf_wr_addr_o, rf_wr_data_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_alu();
      alu_valid_i = 1'b1;
      alu_rd_i    = 5'd5;
      alu_data_i  = 32'h0000_1234;
      push_exp(5'd5, 32'h0000_1234);
      @(negedge clk);
      checks++;
      if (alu_stall_o !== 1'b0) begin
         errors++;
         $display("FAIL alu_stall: got %b, expected 0", alu_stall_o);
      end
      step();
      alu_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (rf_we_o !== 1'b1) begin
         errors++;
         $display("FAIL alu_latency: rf_we_o=%b, expected 1", rf_we_o);
      end
      step();
      // r0 results must vanish
      alu_valid_i = 1'b1;
      alu_rd_i    = 5'd0;
      alu_data_i  = 32'hFFFF_FFFF;
      step();
      alu_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (rf_we_o !== 1'b0) begin
         errors++;
         $display("FAIL alu_r0_drop: rf_we_o=%b, expected 0", rf_we_o);
      end
      wait_drain("alu");
   endtask

   task automatic test_lb_busy();
      issue(5'd3, 3'b000, 2'd2);
      @(negedge clk);
      checks++;
      if (busy_o[3] !== 1'b1 || mem_rsp_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL lb_issue: busy3=%b rsp_rdy=%b, expected 1 1", busy_o[3], mem_rsp_ready_o);
      end
      step();
      respond(32'h0080_0000, 1'b1, 5'd3, 32'hFFFF_FF80);
      @(negedge clk);
      checks++;
      if (busy_o[3] !== 1'b1 || rf_we_o !== 1'b0) begin
         errors++;
         $display("FAIL lb_hold: busy3=%b we=%b, expected 1 0", busy_o[3], rf_we_o);
      end
      step();
      @(negedge clk);
      checks++;
      if (busy_o[3] !== 1'b1 || rf_we_o !== 1'b1) begin
         errors++;
         $display("FAIL lb_write_cycle: busy3=%b we=%b, expected 1 1", busy_o[3], rf_we_o);
      end
      step();
      @(negedge clk);
      checks++;
      if (busy_o[3] !== 1'b0) begin
         errors++;
         $display("FAIL lb_busy_clear: busy3=%b, expected 0", busy_o[3]);
      end
      wait_drain("lb");
   endtask

   task automatic test_formats();
      logic [AW-1:0] rds  [7] = '{5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
      logic [2:0]    f3s  [7] = '{3'b100, 3'b101, 3'b001, 3'b000, 3'b010, 3'b011, 3'b001};
      logic [1:0]    offs [7] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3};
      logic [DW-1:0] wds  [7] = '{32'h0000_F100, 32'hBEEF_0000, 32'h0000_8001, 32'h7F00_0000,
                                  32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_0000};
      logic [DW-1:0] exps [7] = '{32'h0000_00F1, 32'h0000_BEEF, 32'hFFFF_8001, 32'h0000_007F,
                                  32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_A5A5};
      for (int i = 0; i < 7; i++) begin
         issue(rds[i], f3s[i], offs[i]);
         respond(wds[i], 1'b1, rds[i], exps[i]);
         @(negedge clk);
         checks++;
         if (misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL fmt_misalign_%0d: got %b, expected 0", i, misalign_o);
         end
         wait_drain("fmt");
      end
   endtask

   task automatic test_starve();
      logic [DW-1:0] a [4] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
      int idx = 0;
      bit exp_stall;
      issue(5'd9, 3'b010, 2'd0);
      respond(32'hCAFE_0009, 1'b0, 5'd9, 32'h0);
      for (int k = 0; k < 5; k++) begin
         alu_valid_i = 1'b1;
         alu_rd_i    = 5'd10;
         alu_data_i  = a[idx];
         exp_stall   = (k == 3);
         @(negedge clk);
         checks++;
         if (alu_stall_o !== exp_stall) begin
            errors++;
            $display("FAIL starve_stall_%0d: got %b, expected %b", k, alu_stall_o, exp_stall);
         end
         if (exp_stall) begin
            push_exp(5'd9, 32'hCAFE_0009);
         end else begin
            push_exp(5'd10, a[idx]);
            idx++;
         end
         step();
      end
      alu_valid_i = 1'b0;
      wait_drain("starve");
   endtask

   task automatic test_full_and_busy();
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'h5555_5555;
      @(negedge clk);
      checks++;
      if (mem_rsp_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL rsp_before_issue: ready=%b, expected 0", mem_rsp_ready_o);
      end
      step();
      mem_rsp_valid_i = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         ld_issue_valid_i = 1'b1;
         ld_rd_i          = 5'(i);
         ld_funct3_i      = 3'b010;
         ld_byte_off_i    = 2'd0;
         @(negedge clk);
         checks++;
         if (ld_issue_ready_o !== (i <= 4)) begin
            errors++;
            $display("FAIL fifo_ready_%0d: got %b, expected %b", i, ld_issue_ready_o, (i <= 4));
         end
         step();
      end
      ld_issue_valid_i = 1'b0;
      respond(32'h0000_0011, 1'b1, 5'd1, 32'h0000_0011);
      ld_issue_valid_i = 1'b1;
      ld_rd_i          = 5'd2;
      @(negedge clk);
      checks++;
      if (ld_issue_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL busy_refuse: ready=%b, expected 0", ld_issue_ready_o);
      end
      step();
      ld_issue_valid_i = 1'b0;
      ld_rd_i          = 5'd5;
      @(negedge clk);
      checks++;
      if (ld_issue_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL not_full_ready: ready=%b, expected 1", ld_issue_ready_o);
      end
      step();
      respond(32'h0000_0022, 1'b1, 5'd2, 32'h0000_0022);
      respond(32'h0000_0033, 1'b1, 5'd3, 32'h0000_0033);
      respond(32'h0000_0044, 1'b1, 5'd4, 32'h0000_0044);
      wait_drain("full");
   endtask

   task automatic test_reset_inflight();
      logic [31:0] exp_busy;
      issue(5'd12, 3'b010, 2'd0);
      issue(5'd13, 3'b010, 2'd0);
      respond(32'hAAAA_AAAA, 1'b0, 5'd12, 32'h0);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_o !== 32'h0 || rf_we_o !== 1'b0 || mem_rsp_ready_o !== 1'b0 || ld_issue_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_inflight: busy=%h we=%b rsp_rdy=%b iss_rdy=%b, expected 0 0 0 1",
                  busy_o, rf_we_o, mem_rsp_ready_o, ld_issue_ready_o);
      end
      rst_n = 1'b1;
      step();
      ld_issue_valid_i = 1'b1;
      ld_rd_i          = 5'd12;
      ld_funct3_i      = 3'b010;
      ld_byte_off_i    = 2'd0;
      @(negedge clk);
      checks++;
      if (ld_issue_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_issue: ready=%b, expected 1", ld_issue_ready_o);
      end
      step();
      ld_issue_valid_i = 1'b0;
      exp_busy = 32'h0000_1000;
      @(negedge clk);
      checks++;
      if (busy_o !== exp_busy) begin
         errors++;
         $display("FAIL post_reset_busy: got %h, expected %h", busy_o, exp_busy);
      end
      step();
      respond(32'h0C0C_0C0C, 1'b1, 5'd12, 32'h0C0C_0C0C);
      wait_drain("post_reset");
   endtask

   initial begin
      test_reset();
      test_alu();
      test_lb_busy();
      test_formats();
      test_starve();
      test_full_and_busy();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Drives the single register-file write port from two sources.
- Source 1: in-order ALU results.
- Source 2: out-of-band data-memory load responses.
- Queues load tags at issue, extends load data by funct3, and arbitrates the write port with bounded load starvation.
- Exports a per-register pending-load scoreboard that decode uses for hazard stalls.

Parameters:
- DATA_WIDTH, 32, datapath width; load formatting is defined for 32 only.
- ADDR_WIDTH, 5, register index width.
- REG_COUNT, 32, number of architectural registers; width of busy_o.
- LD_DEPTH, 4, outstanding-load tag FIFO depth; power of two, >=2.
- STARVE_LIMIT, 3, consecutive cycles a held load may lose arbitration before the ALU is stalled.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid_i  in  1  ALU result valid this cycle
- alu_rd_i  in  ADDR_WIDTH  ALU destination register
- alu_data_i  in  DATA_WIDTH  ALU result
- alu_stall_o  out  1  ALU input not accepted; upstream holds alu_* stable
- ld_issue_valid_i  in  1  load issued to memory this cycle
- ld_issue_ready_o  out  1  tag FIFO can accept the issue
- ld_rd_i  in  ADDR_WIDTH  load destination register
- ld_funct3_i  in  3  load type
- ld_byte_off_i  in  2  address[1:0]
- mem_rsp_valid_i  in  1  memory read data valid
- mem_rsp_ready_o  out  1  response accepted
- mem_rsp_data_i  in  DATA_WIDTH  aligned memory word
- rf_we_o  out  1  register-file write enable
- rf_wr_addr_o  out  ADDR_WIDTH  write address
- rf_wr_data_o  out  DATA_WIDTH  write data
- busy_o  out  REG_COUNT  bit r=1: load to register r outstanding
- misalign_o  out  1  misaligned-load pulse (feature only; tied 0 otherwise)

Behaviour:
- Reset: all outputs 0 except ld_issue_ready_o, which is 1. FIFO empty, hold register empty, starve counter 0, busy_o all 0. Any in-flight request is dropped; memory is reset together with this block.
- Issue: accepted when ld_issue_valid_i && ld_issue_ready_o.
  - ld_issue_ready_o = !fifo_full && !(ld_rd_i!=0 && busy_o[ld_rd_i]); no same-cycle pop bypass.
  - Accepted issue pushes {rd, funct3, byte_off}. It sets busy[rd] at the next edge when rd!=0.
- Response: mem_rsp_ready_o = !fifo_empty && !hold_valid. A response is accepted when valid && ready.
  - On acceptance, the FIFO head is popped and hold is loaded at the next edge with formatted data and rd. Responses are assumed in issue order.
- Formatting: byte = word >> (8*off); half = word >> (16*off[1]).
  - 000 LB sign-extend byte; 100 LBU zero-extend byte.
  - 001 LH sign-extend half; 101 LHU zero-extend half.
  - 010 LW and all other codes: full word.
- Arbitration, per cycle:
  - The ALU wants the port iff alu_valid_i && alu_rd_i!=0.
  - alu_stall_o = hold_valid && starve_cnt==STARVE_LIMIT. While alu_stall_o is high, the ALU input is ignored.
  - Hold wins if hold_valid and (the ALU does not want the port, or alu_stall_o). Otherwise the ALU wins.
  - starve_cnt increments (saturating) when hold_valid and it loses. It clears when hold drains or hold is empty.
  - ALU results with rd==0 are dropped and never stall.
- Output register: at the edge after arbitration, rf_* take the winner's values with rf_we_o=1. If there is no winner, rf_we_o=0 and addr/data hold their previous values. Latency is 1 cycle from ALU input to rf_we_o.
- Hold with rd==0: drains without a write, taking 1 cycle regardless of the ALU.
- Busy clear:
  - busy[r] clears at the edge ending the cycle in which rf_we_o=1 for a load to r, i.e. when the register file captures the data.
  - A set and a clear of the same bit in one cycle cannot occur because the issue is refused while the bit is busy.
- Not checked: ALU write to a busy register (WAW); decode guarantees absence.

Optional Feature:
- Macro: WB_MISALIGN_TRAP_EN.
- When defined:
  - LH/LHU with off[0]=1, or LW with off!=0, sets misalign_o=1 for 1 cycle, aligned with the cycle the hold would drain.
  - That load performs no register write; its busy bit still clears on the same schedule.
- When undefined: misalign_o is constant 0, and misaligned loads write the shifted data as formatted above.

Test Plan:
- ALU valid rd=5 data=0x1234 for 1 cycle, no loads -> next cycle rf_we_o=1, addr=5, data=0x1234; alu_stall_o stays 0.
- Issue LB rd=3 off=2, then response 0x0080_0000 -> rf write r3=0xFFFF_FF80. busy_o[3] is 1 from the edge after issue until the edge after the write cycle.
- LBU off=1 on 0x0000_F100 -> 0x0000_00F1; LHU off=2 on 0xBEEF_0000 -> 0x0000_BEEF; LH off=0 on 0x0000_8001 -> 0xFFFF_8001.
- Load held while ALU valid continuously (rd!=0), STARVE_LIMIT=3 -> ALU writes 3 cycles, then alu_stall_o=1 for 1 cycle and the load writes; the stalled ALU result is written the following cycle.
- Issue 4 loads (rd 1-4) without responses -> ld_issue_ready_o=0 on the 5th; issue to busy rd=2 is refused with the FIFO not full; a response issued before any load is not accepted (mem_rsp_ready_o=0).
- Assert rst_n low with 2 loads outstanding and hold valid -> busy_o=0, rf_we_o=0, FIFO empty; the first post-reset issue is accepted.
